// File: rtl/serial_sub4.sv
// Bit-serial subtractor: d = a - b - bi, one bit per clock, LSB first, start/busy/done handshake.
// Optional signed-overflow output ovf is built only when SERIAL_SUB_OVF_EN is defined.
module serial_sub4 #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bi,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] d,
`ifdef SERIAL_SUB_OVF_EN
  output logic             bo,
  output logic             ovf
`else
  output logic             bo
`endif
);

  localparam int CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_SHIFT = 2'd1;
  localparam logic [1:0] S_DONE  = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] d_q, d_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             br_q, br_d;
  logic             bo_q, bo_d;
  logic             diff_bit;
  logic             br_nxt;
  logic             last_bit;
`ifdef SERIAL_SUB_OVF_EN
  logic             ovf_q, ovf_d;
`endif

  // Single full-subtractor cell working on the LSBs of the operand shift registers.
  assign diff_bit = a_q[0] ^ b_q[0] ^ br_q;
  assign br_nxt   = (~a_q[0] & b_q[0]) | (~(a_q[0] ^ b_q[0]) & br_q);
  assign last_bit = (cnt_q == CNT_W'(WIDTH - 1));

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    d_d     = d_q;
    cnt_d   = cnt_q;
    br_d    = br_q;
    bo_d    = bo_q;
`ifdef SERIAL_SUB_OVF_EN
    ovf_d   = ovf_q;
`endif
    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_d = S_SHIFT;
          a_d     = a;
          b_d     = b;
          br_d    = bi;
          cnt_d   = '0;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_SHIFT: begin
        a_d   = a_q >> 1;
        b_d   = b_q >> 1;
        br_d  = br_nxt;
        d_d   = {diff_bit, d_q[WIDTH-1:1]};
        cnt_d = cnt_q + CNT_W'(1);
        if (last_bit) begin
          state_d = S_DONE;
          bo_d    = br_nxt;
`ifdef SERIAL_SUB_OVF_EN
          // On the last bit a_q[0]/b_q[0] hold the original sign bits and diff_bit is d[MSB].
          ovf_d   = (a_q[0] ^ b_q[0]) & (diff_bit ^ a_q[0]);
`endif
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      d_q     <= '0;
      cnt_q   <= '0;
      br_q    <= 1'b0;
      bo_q    <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
      ovf_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      d_q     <= d_d;
      cnt_q   <= cnt_d;
      br_q    <= br_d;
      bo_q    <= bo_d;
`ifdef SERIAL_SUB_OVF_EN
      ovf_q   <= ovf_d;
`endif
    end
  end

  // Operand shift registers carry no state visible at the outputs, so they need no reset.
  always_ff @(posedge clk) begin
    a_q <= a_d;
    b_q <= b_d;
  end

  assign busy = (state_q == S_SHIFT);
  assign done = (state_q == S_DONE);
  assign d    = d_q;
  assign bo   = bo_q;
`ifdef SERIAL_SUB_OVF_EN
  assign ovf  = ovf_q;
`endif

endmodule

// File: tb/tb_serial_sub4.sv
// Directed bench for serial_sub4 (WIDTH=4); ovf checks are compiled in with SERIAL_SUB_OVF_EN.
module tb_serial_sub4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic [3:0] a = '0;
  logic [3:0] b = '0;
  logic       bi = 1'b0;
  logic       busy;
  logic       done;
  logic [3:0] d;
  logic       bo;
`ifdef SERIAL_SUB_OVF_EN
  logic       ovf;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  serial_sub4 #(.WIDTH(4)) dut (
    .clk(clk),
    .rst(rst),
    .start(start),
    .a(a),
    .b(b),
    .bi(bi),
    .busy(busy),
    .done(done),
    .d(d),
`ifdef SERIAL_SUB_OVF_EN
    .bo(bo),
    .ovf(ovf)
`else
    .bo(bo)
`endif
  );

  // Issues one start pulse and waits (bounded) for done; returns observed values and timing.
  task automatic run_op(input logic [3:0] ai, input logic [3:0] bv, input logic bin,
                        output logic [3:0] dv, output logic bov, output logic ovv,
                        output int lat, output int nbusy, output logic busy_at_done);
    @(negedge clk);
    a = ai; b = bv; bi = bin; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    lat = 1;
    nbusy = 0;
    while (done !== 1'b1 && lat < 20) begin
      if (busy === 1'b1) nbusy++;
      @(negedge clk);
      lat++;
    end
    dv = d;
    bov = bo;
    busy_at_done = busy;
`ifdef SERIAL_SUB_OVF_EN
    ovv = ovf;
`else
    ovv = 1'b0;
`endif
  endtask

  task automatic test_reset();
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy got=%b want=0", busy); end
    n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL reset_done got=%b want=0", done); end
    n_cmp++; if (d !== 4'b0000) begin n_bad++; $display("FAIL reset_d got=%b want=0000", d); end
    n_cmp++; if (bo !== 1'b0) begin n_bad++; $display("FAIL reset_bo got=%b want=0", bo); end
`ifdef SERIAL_SUB_OVF_EN
    n_cmp++; if (ovf !== 1'b0) begin n_bad++; $display("FAIL reset_ovf got=%b want=0", ovf); end
`endif
    rst = 1'b0;
  endtask

  task automatic test_basic();
    logic [3:0] dv; logic bov, ovv, bad; int lat, nb;
    run_op(4'b0111, 4'b0011, 1'b0, dv, bov, ovv, lat, nb, bad);
    n_cmp++; if (lat !== 5) begin n_bad++; $display("FAIL basic_latency got=%0d want=5", lat); end
    n_cmp++; if (nb !== 4) begin n_bad++; $display("FAIL basic_busy_cycles got=%0d want=4", nb); end
    n_cmp++; if (bad !== 1'b0) begin n_bad++; $display("FAIL basic_busy_with_done got=%b want=0", bad); end
    n_cmp++; if (dv !== 4'b0100) begin n_bad++; $display("FAIL basic_d got=%b want=0100", dv); end
    n_cmp++; if (bov !== 1'b0) begin n_bad++; $display("FAIL basic_bo got=%b want=0", bov); end
    @(negedge clk);
    n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL basic_done_width got=%b want=0", done); end
    n_cmp++; if (d !== 4'b0100) begin n_bad++; $display("FAIL basic_d_hold got=%b want=0100", d); end
  endtask

  task automatic test_borrow();
    logic [3:0] dv; logic bov, ovv, bad; int lat, nb;
    run_op(4'b0000, 4'b0001, 1'b0, dv, bov, ovv, lat, nb, bad);
    n_cmp++; if (dv !== 4'b1111) begin n_bad++; $display("FAIL borrow1_d got=%b want=1111", dv); end
    n_cmp++; if (bov !== 1'b1) begin n_bad++; $display("FAIL borrow1_bo got=%b want=1", bov); end
    run_op(4'b0101, 4'b0101, 1'b1, dv, bov, ovv, lat, nb, bad);
    n_cmp++; if (dv !== 4'b1111) begin n_bad++; $display("FAIL borrow2_d got=%b want=1111", dv); end
    n_cmp++; if (bov !== 1'b1) begin n_bad++; $display("FAIL borrow2_bo got=%b want=1", bov); end
  endtask

`ifdef SERIAL_SUB_OVF_EN
  task automatic test_ovf();
    logic [3:0] dv; logic bov, ovv, bad; int lat, nb;
    run_op(4'b1000, 4'b0001, 1'b0, dv, bov, ovv, lat, nb, bad);
    n_cmp++; if (dv !== 4'b0111) begin n_bad++; $display("FAIL ovf1_d got=%b want=0111", dv); end
    n_cmp++; if (bov !== 1'b0) begin n_bad++; $display("FAIL ovf1_bo got=%b want=0", bov); end
    n_cmp++; if (ovv !== 1'b1) begin n_bad++; $display("FAIL ovf1_ovf got=%b want=1", ovv); end
    run_op(4'b0011, 4'b0001, 1'b0, dv, bov, ovv, lat, nb, bad);
    n_cmp++; if (dv !== 4'b0010) begin n_bad++; $display("FAIL ovf2_d got=%b want=0010", dv); end
    n_cmp++; if (ovv !== 1'b0) begin n_bad++; $display("FAIL ovf2_ovf got=%b want=0", ovv); end
  endtask
`endif

  task automatic test_ignore_start();
    int lat;
    @(negedge clk);
    a = 4'b0111; b = 4'b0011; bi = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    a = 4'b0001; b = 4'b0010; bi = 1'b1; start = 1'b1;
    @(negedge clk);
    start = 1'b0; a = 4'b1111; b = 4'b1111;
    lat = 3;
    while (done !== 1'b1 && lat < 20) begin @(negedge clk); lat++; end
    n_cmp++; if (lat !== 5) begin n_bad++; $display("FAIL ignore_latency got=%0d want=5", lat); end
    n_cmp++; if (d !== 4'b0100) begin n_bad++; $display("FAIL ignore_d got=%b want=0100", d); end
    n_cmp++; if (bo !== 1'b0) begin n_bad++; $display("FAIL ignore_bo got=%b want=0", bo); end
  endtask

  task automatic test_back_to_back();
    int lat;
    @(negedge clk);
    a = 4'b1001; b = 4'b0011; bi = 1'b0; start = 1'b1;
    @(negedge clk);
    a = 4'b0010; b = 4'b0101; bi = 1'b1;
    lat = 1;
    while (done !== 1'b1 && lat < 20) begin @(negedge clk); lat++; end
    n_cmp++; if (lat !== 5) begin n_bad++; $display("FAIL b2b_first_latency got=%0d want=5", lat); end
    n_cmp++; if (d !== 4'b0110) begin n_bad++; $display("FAIL b2b_first_d got=%b want=0110", d); end
    n_cmp++; if (bo !== 1'b0) begin n_bad++; $display("FAIL b2b_first_bo got=%b want=0", bo); end
    @(negedge clk);
    n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL b2b_restart_busy got=%b want=1", busy); end
    start = 1'b0;
    lat = 1;
    while (done !== 1'b1 && lat < 20) begin @(negedge clk); lat++; end
    n_cmp++; if (lat !== 5) begin n_bad++; $display("FAIL b2b_second_latency got=%0d want=5", lat); end
    n_cmp++; if (d !== 4'b1100) begin n_bad++; $display("FAIL b2b_second_d got=%b want=1100", d); end
    n_cmp++; if (bo !== 1'b1) begin n_bad++; $display("FAIL b2b_second_bo got=%b want=1", bo); end
  endtask

  task automatic test_reset_mid();
    logic [3:0] dv; logic bov, ovv, bad; int lat, nb, seen;
    @(negedge clk);
    a = 4'b0111; b = 4'b0011; bi = 1'b1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL midrst_busy got=%b want=0", busy); end
    n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL midrst_done got=%b want=0", done); end
    n_cmp++; if (d !== 4'b0000) begin n_bad++; $display("FAIL midrst_d got=%b want=0000", d); end
    n_cmp++; if (bo !== 1'b0) begin n_bad++; $display("FAIL midrst_bo got=%b want=0", bo); end
    rst = 1'b0;
    seen = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (done === 1'b1 || busy === 1'b1) seen++;
    end
    n_cmp++; if (seen !== 0) begin n_bad++; $display("FAIL midrst_no_done got=%0d want=0", seen); end
    run_op(4'b0110, 4'b0001, 1'b0, dv, bov, ovv, lat, nb, bad);
    n_cmp++; if (lat !== 5) begin n_bad++; $display("FAIL midrst_fresh_latency got=%0d want=5", lat); end
    n_cmp++; if (dv !== 4'b0101) begin n_bad++; $display("FAIL midrst_fresh_d got=%b want=0101", dv); end
    n_cmp++; if (bov !== 1'b0) begin n_bad++; $display("FAIL midrst_fresh_bo got=%b want=0", bov); end
  endtask

  task automatic test_sweep();
    logic [3:0] dv, exp_d; logic bov, ovv, bad, exp_bo, exp_ovf; int lat, nb, diff;
    for (int c = 0; c < 2; c++) begin
      for (int x = 0; x < 16; x++) begin
        for (int y = 0; y < 16; y++) begin
          run_op(4'(x), 4'(y), 1'(c), dv, bov, ovv, lat, nb, bad);
          diff = x - y - c;
          exp_d = 4'(diff & 15);
          exp_bo = (diff < 0);
          exp_ovf = ((x >> 3) != (y >> 3)) && ((exp_d >> 3) != 4'(x >> 3));
          n_cmp++; if (dv !== exp_d || lat !== 5) begin
            n_bad++; $display("FAIL sweep_d a=%0d b=%0d bi=%0d got=%b lat=%0d want=%b lat=5", x, y, c, dv, lat, exp_d);
          end
          n_cmp++; if (bov !== exp_bo) begin
            n_bad++; $display("FAIL sweep_bo a=%0d b=%0d bi=%0d got=%b want=%b", x, y, c, bov, exp_bo);
          end
`ifdef SERIAL_SUB_OVF_EN
          n_cmp++; if (ovv !== exp_ovf) begin
            n_bad++; $display("FAIL sweep_ovf a=%0d b=%0d bi=%0d got=%b want=%b", x, y, c, ovv, exp_ovf);
          end
`else
          if (ovv !== 1'b0 && exp_ovf === 1'bx) n_bad = n_bad;
`endif
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_borrow();
`ifdef SERIAL_SUB_OVF_EN
    test_ovf();
`endif
    test_ignore_start();
    test_back_to_back();
    test_reset_mid();
    test_sweep();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
